// File: rtl/tile_switch_router_if.sv
// Host-side and tile-side bus bundle for tile_switch_router.
// The master side is the environment (host plus tiles); the slave side is the router.
interface tile_switch_router_if #(
    parameter int NUM_TILES = 4
);
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [8*NUM_TILES-1:0] tile_switch_in;
    logic [8*NUM_TILES-1:0] tile_switch_out;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   err;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tile_switch_in,
        output tile_switch_out,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  busy,
        input  err
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tile_switch_in,
        input  tile_switch_out,
        output out_data,
        output out_valid,
        input  out_ready,
        output busy,
        output err
    );
endinterface

// File: rtl/tile_switch_router.sv
// tile_switch_router: decodes a host byte stream into per-tile write frames
// (address + payload) and read frames (address only). Each tile sees a
// level-held byte from its own holding register; reads sample the tile's
// output after a fixed settle delay and return it on a valid/ready port.

// Protocol properties of the router's external behaviour.
module tile_switch_router_chk (
    input logic       clk,
    input logic       rst,
    input logic       in_ready,
    input logic       busy,
    input logic       err,
    input logic       out_valid,
    input logic       out_ready,
    input logic [7:0] out_data
);
    // A presented result stays put until the host accepts it.
    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)))
        else $error("result dropped or changed before acceptance");

    // No new host byte is taken while a result is outstanding.
    a_no_accept_during_resp: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> !in_ready)
        else $error("in_ready high while result pending");

    // When idle the router is always willing to take an address byte.
    a_idle_ready: assert property (@(posedge clk) disable iff (rst)
        !busy |-> in_ready)
        else $error("idle but not ready");

    // The error flag is sticky until reset.
    a_err_sticky: assert property (@(posedge clk) disable iff (rst)
        err |=> err)
        else $error("err cleared without reset");
endmodule

module tile_switch_router #(
    parameter int NUM_TILES     = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    tile_switch_router_if.slave bus
);
    localparam int         CNT_W       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [4:0] NUM_TILES_L = 5'(NUM_TILES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_WAIT    = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // A tile index is only meaningful below NUM_TILES.
    function automatic logic idx_out_of_range(input logic [3:0] idx);
        return ({1'b0, idx} >= NUM_TILES_L);
    endfunction

    state_t           state_r;
    logic             bcast_r;
    logic [3:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       hold_r [NUM_TILES];
    logic [7:0]       tile_out_s [NUM_TILES];
    logic [7:0]       out_data_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             err_r;

    logic             in_fire_s;
    logic             idx_bad_s;
    logic             wr_fire_s;
    logic             rd_sample_s;
    logic [7:0]       rd_sel_s;

    // Flatten/unflatten the per-tile byte lanes.
    for (genvar g = 0; g < NUM_TILES; g++) begin : g_lane
        assign bus.tile_switch_in[g*8 +: 8] = hold_r[g];
        assign tile_out_s[g]                = bus.tile_switch_out[g*8 +: 8];
    end

    // Decode handshake and frame-completion events from the current state.
    always_comb begin
        in_fire_s = bus.in_valid && in_ready_r;
        idx_bad_s = idx_out_of_range(idx_r);
        if (state_r == S_PAYLOAD) begin
            wr_fire_s = in_fire_s;
        end else begin
            wr_fire_s = 1'b0;
        end
        if (state_r == S_WAIT) begin
            rd_sample_s = (cnt_r == CNT_W'(1));
        end else begin
            rd_sample_s = 1'b0;
        end
    end

    // Select the addressed tile's output byte (zero when no lane matches).
    always_comb begin
        rd_sel_s = 8'h00;
        for (int i = 0; i < NUM_TILES; i++) begin
            rd_sel_s = rd_sel_s | ({8{4'(i) == idx_r}} & tile_out_s[i]);
        end
    end

    // Per-tile holding registers: cleared by reset, written only by a completed write frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TILES; i++) begin
                hold_r[i] <= 8'h00;
            end
        end else if (wr_fire_s) begin
            for (int i = 0; i < NUM_TILES; i++) begin
                if (bcast_r || (4'(i) == idx_r)) begin
                    hold_r[i] <= bus.in_data;
                end else begin
                    hold_r[i] <= hold_r[i];
                end
            end
        end
    end

    // Frame FSM with registered handshake, status and read-result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            bcast_r     <= 1'b0;
            idx_r       <= 4'h0;
            cnt_r       <= '0;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_fire_s) begin
                        idx_r   <= bus.in_data[3:0];
                        bcast_r <= bus.in_data[7];
                        busy_r  <= 1'b1;
                        if (bus.in_data[6]) begin
                            // Read: broadcast bit has no meaning here.
                            state_r    <= S_WAIT;
                            cnt_r      <= CNT_W'(SETTLE_CYCLES);
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r    <= S_PAYLOAD;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (wr_fire_s) begin
                        state_r    <= S_IDLE;
                        busy_r     <= 1'b0;
                        in_ready_r <= 1'b1;
                        if (!bcast_r && idx_bad_s) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (rd_sample_s) begin
                        state_r     <= S_RESP;
                        out_valid_r <= 1'b1;
                        if (idx_bad_s) begin
                            out_data_r <= 8'hFF;
                            err_r      <= 1'b1;
                        end else begin
                            out_data_r <= rd_sel_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (out_valid_r && bus.out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.err       = err_r;

    tile_switch_router_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready_r),
        .busy      (busy_r),
        .err       (err_r),
        .out_valid (out_valid_r),
        .out_ready (bus.out_ready),
        .out_data  (out_data_r)
    );
endmodule

// File: tb/tb_tile_switch_router.sv
// Bench for tile_switch_router: directed frames followed by random write/read
// traffic, checked against a frame-level model and a read-result scoreboard.
module tb_tile_switch_router;
    localparam int NT     = 4;
    localparam int SETTLE = 2;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [7:0] m_hold [NT];
    logic       m_err;
    exp_t       sb_q [$];
    exp_t       cur;
    logic       in_resp = 1'b0;

    tile_switch_router_if #(.NUM_TILES(NT)) bus ();

    tile_switch_router #(.NUM_TILES(NT), .SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every tile lane and the error flag with the model.
    task automatic check_state(input string name);
        for (int i = 0; i < NT; i++) begin
            chk($sformatf("%s_slice%0d", name, i), {24'h0, bus.tile_switch_in[i*8 +: 8]}, {24'h0, m_hold[i]});
        end
        chk({name, "_err"}, {31'h0, bus.err}, {31'h0, m_err});
    endtask

    // Monitor: pops one expected result per presented response and checks timing and stability.
    always @(negedge clk) begin
        if (rst) begin
            in_resp = 1'b0;
        end else if (bus.out_valid) begin
            if (!in_resp) begin
                chk("resp_expected", {31'h0, sb_q.size() > 0}, 32'h1);
                if (sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                    chk("resp_data", {24'h0, bus.out_data}, {24'h0, cur.data});
                    chk("resp_latency", cyc, cur.due);
                end
                in_resp = 1'b1;
            end else begin
                chk("resp_stable", {24'h0, bus.out_data}, {24'h0, cur.data});
            end
            if (bus.out_ready) in_resp = 1'b0;
        end else if (in_resp) begin
            chk("resp_dropped", {31'h0, bus.out_valid}, 32'h1);
            in_resp = 1'b0;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_hold[i] = 8'h00;
        m_err = 1'b0;
    endtask

    // Frame-level write rule: broadcast, single valid lane, or flag a bad index.
    task automatic model_write(input logic [7:0] addr, input logic [7:0] pay);
        int idx;
        idx = int'(addr[3:0]);
        if (addr[7]) begin
            for (int i = 0; i < NT; i++) m_hold[i] = pay;
        end else if (idx < NT) begin
            m_hold[idx] = pay;
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Present one byte and return once it has been taken (called and returns at posedge+1).
    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        acc          = cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic write_frame(input logic [7:0] addr, input logic [7:0] pay, input int gap);
        int acc;
        send_byte(addr, acc);
        @(negedge clk);
        check_state("pre_payload");
        chk("pre_payload_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("pre_payload_busy", {31'h0, bus.busy}, 32'h1);
        @(posedge clk);
        #1;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("gap_in_ready", {31'h0, bus.in_ready}, 32'h1);
            @(posedge clk);
            #1;
        end
        send_byte(pay, acc);
        model_write(addr, pay);
        @(negedge clk);
        check_state("write");
        chk("write_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    // Issue a read, hold off acceptance for 'hold' cycles, then accept.
    task automatic do_read(input logic [7:0] addr, input int hold);
        int         acc;
        int         n;
        int         idx;
        logic [7:0] e;
        idx = int'(addr[3:0]);
        if (idx < NT) begin
            e = bus.tile_switch_out[idx*8 +: 8];
        end else begin
            e = 8'hFF;
        end
        bus.out_ready = 1'b0;
        send_byte(addr, acc);
        sb_q.push_back('{e, acc + SETTLE});
        if (idx >= NT) m_err = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 50);
        chk("read_valid_seen", {31'h0, bus.out_valid}, 32'h1);
        chk("read_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
        chk("read_busy", {31'h0, bus.busy}, 32'h1);
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("read_valid_cleared", {31'h0, bus.out_valid}, 32'h0);
        chk("read_in_ready_back", {31'h0, bus.in_ready}, 32'h1);
        chk("read_sb_drained", sb_q.size(), 32'h0);
        check_state("after_read");
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_tiles();
        for (int i = 0; i < NT; i++) bus.tile_switch_out[i*8 +: 8] = 8'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc;
        logic [7:0] a;
        bus.in_data         = 8'h00;
        bus.in_valid        = 1'b0;
        bus.out_ready       = 1'b0;
        bus.tile_switch_out = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_state("reset");
        chk("reset_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        chk("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("reset_out_data", {24'h0, bus.out_data}, 32'h0);
        @(posedge clk);
        #1;

        // Single-lane write, then broadcast.
        write_frame(8'h02, 8'h05, 0);
        write_frame(8'h80, 8'h50, 0);

        // Read lane 1 with delayed acceptance.
        randomize_tiles();
        bus.tile_switch_out[15:8] = 8'h2A;
        do_read(8'h41, 3);

        // Bad index on write and on read.
        write_frame(8'h07, 8'h33, 0);
        randomize_tiles();
        do_read(8'h47, 1);

        // Idle gap between address and payload.
        write_frame(8'h01, 8'h9C, 4);

        // Reset after an address byte: next byte is a fresh address.
        send_byte(8'h03, acc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_state("midframe_reset");
        chk("midframe_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("midframe_busy", {31'h0, bus.busy}, 32'h0);
        chk("midframe_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("midframe_out_data", {24'h0, bus.out_data}, 32'h0);
        @(posedge clk);
        #1;
        write_frame(8'h11, 8'h6B, 0);

        // Random mixed traffic.
        for (int k = 0; k < 40; k++) begin
            a = 8'($urandom);
            a[3:0] = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 2) begin
                a[6] = 1'b1;
                randomize_tiles();
                do_read(a, $urandom_range(0, 3));
            end else begin
                a[6] = 1'b0;
                a[7] = ($urandom_range(0, 7) == 0);
                write_frame(a, 8'($urandom), $urandom_range(0, 2));
            end
        end

        chk("final_sb_empty", sb_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
